// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a first-word-fall-through
// receive FIFO. It also flags framing errors and FIFO overflow, and drives an interrupt.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_err,
  output logic       irq
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             sync1_q, rx_s_q, rx_prev_q;
  logic             push, ferr_set;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_pop, push_ok, ovf_set;

  // Two-flop synchroniser plus previous-sample flop; all idle high out of reset.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Receiver next state: start on a falling edge, sample mid-bit thereafter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          state_d  = IDLE;
          push     = rx_s_q;
          ferr_set = !rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = rd_en && (count_q != '0);
  assign push_ok = push && ((count_q != DEPTH_C) || do_pop);
  assign ovf_set = push && !push_ok;

  // FIFO pointers, occupancy count and sticky error flags.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(do_pop);
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovf_set)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_valid  = (count_q != '0);
  assign fifo_full = (count_q == DEPTH_C);
  assign rd_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign irq       = rx_valid | frame_err | overflow;

endmodule
